// File: rtl/axi_mem_tester_pkg.sv
// Shared FSM state type, AXI encodings and the per-lane test pattern for axi_mem_tester.
// The AXI width macros default here so every file of the tester sees one consistent set.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 64
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 512
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI4_BURST_WIDTH
`define AXI4_BURST_WIDTH 2
`endif
`ifndef AXI4_LOCK_WIDTH
`define AXI4_LOCK_WIDTH 1
`endif
`ifndef AXI4_CACHE_WIDTH
`define AXI4_CACHE_WIDTH 4
`endif
`ifndef AXI4_PROT_WIDTH
`define AXI4_PROT_WIDTH 3
`endif
`ifndef AXI4_QOS_WIDTH
`define AXI4_QOS_WIDTH 4
`endif
`ifndef AXI4_REGION_WIDTH
`define AXI4_REGION_WIDTH 4
`endif
`ifndef AXI4_RESP_WIDTH
`define AXI4_RESP_WIDTH 2
`endif

package axi_mem_tester_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      FIN     = 3'd5
   } state_e;

   localparam logic [`AXI4_BURST_WIDTH-1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [`AXI4_RESP_WIDTH-1:0]  AXI_RESP_OKAY  = 2'b00;

   function automatic logic [63:0] pattern_lane(input logic [15:0] line,
                                                 input logic [31:0] lane,
                                                 input logic [63:0] seed);
      return {16'h0000, line, lane} ^ seed;
   endfunction

endpackage

// File: rtl/axi_mem_tester_pattern.sv
// Combinational line index -> full-width test pattern, one 64-bit lane at a time.
module axi_mem_tester_pattern
   import axi_mem_tester_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 512,
   parameter logic [63:0] SEED       = 64'hA5A5_5A5A_0F0F_F0F0
) (
   input  logic [15:0]           line_i,
   output logic [DATA_WIDTH-1:0] pattern_o
);

   localparam int unsigned LANES = DATA_WIDTH / 64;

   always_comb begin
      pattern_o = '0;
      for (int k = 0; k < LANES; k++) begin
         pattern_o[k*64 +: 64] = pattern_lane(line_i, 32'(k), SEED);
      end
   end

endmodule

// File: rtl/axi_mem_tester.sv
// AXI4 memory tester: writes a seeded pattern to NUM_LINES single-beat lines, reads them
// back and counts mismatching or erroring beats, one transaction outstanding at a time.
module axi_mem_tester
   import axi_mem_tester_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR = 64'h0,
   parameter int unsigned NUM_LINES = 16,
   parameter logic [63:0] SEED      = 64'hA5A5_5A5A_0F0F_F0F0,
   parameter int unsigned TEST_ID   = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic                             pass,
   output logic [15:0]                      err_count,
   output logic [15:0]                      first_err_line,
   output logic [`AXI_ID_WIDTH-1:0]         m_axi_awid,
   output logic [`AXI_ADDR_WIDTH-1:0]       m_axi_awaddr,
   output logic [`AXI_LEN_WIDTH-1:0]        m_axi_awlen,
   output logic [`AXI_SIZE_WIDTH-1:0]       m_axi_awsize,
   output logic [`AXI4_BURST_WIDTH-1:0]     m_axi_awburst,
   output logic [`AXI4_LOCK_WIDTH-1:0]      m_axi_awlock,
   output logic [`AXI4_CACHE_WIDTH-1:0]     m_axi_awcache,
   output logic [`AXI4_PROT_WIDTH-1:0]      m_axi_awprot,
   output logic [`AXI4_QOS_WIDTH-1:0]       m_axi_awqos,
   output logic [`AXI4_REGION_WIDTH-1:0]    m_axi_awregion,
   output logic                             m_axi_awvalid,
   input  logic                             m_axi_awready,
   output logic [`AXI_DATA_WIDTH-1:0]       m_axi_wdata,
   output logic [`AXI_DATA_WIDTH/8-1:0]     m_axi_wstrb,
   output logic                             m_axi_wlast,
   output logic                             m_axi_wvalid,
   input  logic                             m_axi_wready,
   input  logic [`AXI_ID_WIDTH-1:0]         m_axi_bid,
   input  logic [`AXI4_RESP_WIDTH-1:0]      m_axi_bresp,
   input  logic                             m_axi_bvalid,
   output logic                             m_axi_bready,
   output logic [`AXI_ID_WIDTH-1:0]         m_axi_arid,
   output logic [`AXI_ADDR_WIDTH-1:0]       m_axi_araddr,
   output logic [`AXI_LEN_WIDTH-1:0]        m_axi_arlen,
   output logic [`AXI_SIZE_WIDTH-1:0]       m_axi_arsize,
   output logic [`AXI4_BURST_WIDTH-1:0]     m_axi_arburst,
   output logic [`AXI4_LOCK_WIDTH-1:0]      m_axi_arlock,
   output logic [`AXI4_CACHE_WIDTH-1:0]     m_axi_arcache,
   output logic [`AXI4_PROT_WIDTH-1:0]      m_axi_arprot,
   output logic [`AXI4_QOS_WIDTH-1:0]       m_axi_arqos,
   output logic [`AXI4_REGION_WIDTH-1:0]    m_axi_arregion,
   output logic                             m_axi_arvalid,
   input  logic                             m_axi_arready,
   input  logic [`AXI_ID_WIDTH-1:0]         m_axi_rid,
   input  logic [`AXI_DATA_WIDTH-1:0]       m_axi_rdata,
   input  logic [`AXI4_RESP_WIDTH-1:0]      m_axi_rresp,
   input  logic                             m_axi_rlast,
   input  logic                             m_axi_rvalid,
   output logic                             m_axi_rready
);

   localparam int unsigned DW    = `AXI_DATA_WIDTH;
   localparam int unsigned AW    = `AXI_ADDR_WIDTH;
   localparam int unsigned BYTES = DW / 8;
   localparam logic [`AXI_SIZE_WIDTH-1:0] BEAT_SIZE = `AXI_SIZE_WIDTH'($clog2(BYTES));
   localparam logic [`AXI_ID_WIDTH-1:0]   ID        = `AXI_ID_WIDTH'(TEST_ID);
   localparam logic [15:0]                LAST_LINE = 16'(NUM_LINES - 1);

   state_e          state_q;
   logic [15:0]     line_q, line_d, pat_line_s;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, pattern_s;
   logic            awvalid_q, wvalid_q, aw_done_q, w_done_q, bready_q, arvalid_q, rready_q;
   logic            busy_q, done_q, pass_q;
   logic [15:0]     err_q, first_err_q, err_inc_s;
   logic            last_s, aw_hs_s, w_hs_s, b_hs_s, r_hs_s, b_err_s, r_err_s;

   // Write data is prepared for the line about to be issued; the read check uses the current line.
   axi_mem_tester_pattern #(
      .DATA_WIDTH (DW),
      .SEED       (SEED)
   ) u_pattern (
      .line_i    (pat_line_s),
      .pattern_o (pattern_s)
   );

   always_comb begin
      last_s     = (line_q == LAST_LINE);
      line_d     = ((state_q == IDLE) || last_s) ? 16'h0000 : line_q + 16'h0001;
      pat_line_s = (state_q == RD_RESP) ? line_q : line_d;
      addr_d     = BASE_ADDR[AW-1:0] + (AW'(line_d) * AW'(BYTES));
      aw_hs_s    = awvalid_q & m_axi_awready;
      w_hs_s     = wvalid_q & m_axi_wready;
      b_hs_s     = bready_q & m_axi_bvalid;
      r_hs_s     = rready_q & m_axi_rvalid;
      b_err_s    = (m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != ID);
      r_err_s    = (m_axi_rdata != pattern_s) || (m_axi_rresp != AXI_RESP_OKAY) ||
                   !m_axi_rlast || (m_axi_rid != ID);
      err_inc_s  = (err_q == 16'hFFFF) ? err_q : err_q + 16'h0001;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         line_q      <= 16'h0000;
         addr_q      <= '0;
         wdata_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= 16'h0000;
         first_err_q <= 16'h0000;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  err_q       <= 16'h0000;
                  first_err_q <= 16'h0000;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  line_q      <= 16'h0000;
                  addr_q      <= addr_d;
                  wdata_q     <= pattern_s;
                  awvalid_q   <= 1'b1;
                  wvalid_q    <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= WR_REQ;
               end
            end
            WR_REQ: begin
               if (aw_hs_s) awvalid_q <= 1'b0;
               if (w_hs_s)  wvalid_q  <= 1'b0;
               // AW and W may complete in either order; remember whichever finished first.
               if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  bready_q  <= 1'b1;
                  state_q   <= WR_RESP;
               end else begin
                  aw_done_q <= aw_done_q | aw_hs_s;
                  w_done_q  <= w_done_q | w_hs_s;
               end
            end
            WR_RESP: begin
               if (b_hs_s) begin
                  bready_q <= 1'b0;
                  if (b_err_s) begin
                     err_q <= err_inc_s;
                     if (err_q == 16'h0000) first_err_q <= line_q;
                  end
                  line_q <= line_d;
                  addr_q <= addr_d;
                  if (last_s) begin
                     arvalid_q <= 1'b1;
                     state_q   <= RD_REQ;
                  end else begin
                     wdata_q   <= pattern_s;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= WR_REQ;
                  end
               end
            end
            RD_REQ: begin
               if (arvalid_q && m_axi_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (r_hs_s) begin
                  rready_q <= 1'b0;
                  if (r_err_s) begin
                     err_q <= err_inc_s;
                     if (err_q == 16'h0000) first_err_q <= line_q;
                  end
                  line_q <= line_d;
                  addr_q <= addr_d;
                  if (last_s) begin
                     state_q <= FIN;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= RD_REQ;
                  end
               end
            end
            FIN: begin
               done_q  <= 1'b1;
               pass_q  <= (err_q == 16'h0000);
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_line = first_err_q;

   assign m_axi_awid     = ID;
   assign m_axi_awaddr   = addr_q;
   assign m_axi_awlen    = {`AXI_LEN_WIDTH{1'b0}};
   assign m_axi_awsize   = BEAT_SIZE;
   assign m_axi_awburst  = AXI_BURST_INCR;
   assign m_axi_awlock   = {`AXI4_LOCK_WIDTH{1'b0}};
   assign m_axi_awcache  = {`AXI4_CACHE_WIDTH{1'b0}};
   assign m_axi_awprot   = {`AXI4_PROT_WIDTH{1'b0}};
   assign m_axi_awqos    = {`AXI4_QOS_WIDTH{1'b0}};
   assign m_axi_awregion = {`AXI4_REGION_WIDTH{1'b0}};
   assign m_axi_awvalid  = awvalid_q;
   assign m_axi_wdata    = wdata_q;
   assign m_axi_wstrb    = {(DW/8){1'b1}};
   assign m_axi_wlast    = 1'b1;
   assign m_axi_wvalid   = wvalid_q;
   assign m_axi_bready   = bready_q;
   assign m_axi_arid     = ID;
   assign m_axi_araddr   = addr_q;
   assign m_axi_arlen    = {`AXI_LEN_WIDTH{1'b0}};
   assign m_axi_arsize   = BEAT_SIZE;
   assign m_axi_arburst  = AXI_BURST_INCR;
   assign m_axi_arlock   = {`AXI4_LOCK_WIDTH{1'b0}};
   assign m_axi_arcache  = {`AXI4_CACHE_WIDTH{1'b0}};
   assign m_axi_arprot   = {`AXI4_PROT_WIDTH{1'b0}};
   assign m_axi_arqos    = {`AXI4_QOS_WIDTH{1'b0}};
   assign m_axi_arregion = {`AXI4_REGION_WIDTH{1'b0}};
   assign m_axi_arvalid  = arvalid_q;
   assign m_axi_rready   = rready_q;

endmodule
